// File: rtl/alarm_pkg.sv
// Shared alarm definitions: annunciator state encoding and default timing constants.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } alm_state_t;

    localparam int RING_SECS_D   = 60;
    localparam int SNOOZE_SECS_D = 540;
    localparam int MAX_SNOOZE_D  = 3;

endpackage

// File: rtl/alarm_edge_det.sv
// One-bit rising-edge detector. The history register resets to RST_VAL so a
// level that is already high when reset releases can be treated as "seen".
module alarm_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clock_1Sec,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Remember the previous level to detect a low-to-high transition.
    always_ff @(posedge Clock_1Sec) begin
        if (Reset) level_q <= RST_VAL;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm annunciator: drives the buzzer with a 1 s on / 1 s off pattern,
// supports a bounded number of snoozes and auto-offs after a ring timeout.
//
// state  | meaning
// IDLE   | waiting for a new alarm rising edge while enabled
// RING   | buzzer toggling, Remaining counts down the ring episode
// SNOOZE | buzzer silent, Remaining counts down to the next ring
// DONE   | episode finished; held until Alarm drops so the same minute cannot re-trigger
module alarm_snooze_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_D,
    parameter int SNOOZE_SECS = SNOOZE_SECS_D,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_D,
    parameter int TIMER_W     = 10
) (
    input  logic               Clock_1Sec,
    input  logic               Reset,
    input  logic               Alarm,
    input  logic               AlarmEnable,
    input  logic               SnoozeBtn,
    input  logic               StopBtn,
    output logic               Buzzer,
    output logic               Ringing,
    output logic               Snoozing,
    output logic [1:0]         SnoozeCnt,
    output logic [TIMER_W-1:0] Remaining
);

    localparam logic [TIMER_W-1:0] RING_LOAD   = TIMER_W'(RING_SECS - 1);
    localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]         SNOOZE_MAX  = 2'(MAX_SNOOZE);

    alm_state_t         state, state_n;
    logic [TIMER_W-1:0] remaining_n;
    logic [1:0]         snooze_cnt_n;
    logic               buzzer_n;
    logic               alm_rise, snz, stp;

    // Alarm history resets high so an Alarm already asserted at reset release does not ring.
    alarm_edge_det #(.RST_VAL(1'b1)) u_alarm_edge (
        .Clock_1Sec (Clock_1Sec),
        .Reset      (Reset),
        .level      (Alarm),
        .rise       (alm_rise)
    );

    alarm_edge_det #(.RST_VAL(1'b0)) u_snooze_edge (
        .Clock_1Sec (Clock_1Sec),
        .Reset      (Reset),
        .level      (SnoozeBtn),
        .rise       (snz)
    );

    alarm_edge_det #(.RST_VAL(1'b0)) u_stop_edge (
        .Clock_1Sec (Clock_1Sec),
        .Reset      (Reset),
        .level      (StopBtn),
        .rise       (stp)
    );

    // State, timer, snooze count and all outputs update together so status flags carry no extra latency.
    always_ff @(posedge Clock_1Sec) begin
        if (Reset) begin
            state     <= IDLE;
            Remaining <= '0;
            SnoozeCnt <= 2'd0;
            Buzzer    <= 1'b0;
            Ringing   <= 1'b0;
            Snoozing  <= 1'b0;
        end else begin
            state     <= state_n;
            Remaining <= remaining_n;
            SnoozeCnt <= snooze_cnt_n;
            Buzzer    <= buzzer_n;
            Ringing   <= (state_n == RING);
            Snoozing  <= (state_n == SNOOZE);
        end
    end

    // Next-state logic; priority is enable loss, then stop, then snooze, then timer expiry.
    always_comb begin
        state_n      = state;
        remaining_n  = Remaining;
        snooze_cnt_n = SnoozeCnt;
        buzzer_n     = 1'b0;

        unique case (state)
            IDLE: begin
                remaining_n = '0;
                if (alm_rise && AlarmEnable) begin
                    state_n     = RING;
                    remaining_n = RING_LOAD;
                    buzzer_n    = 1'b1;
                end
            end

            RING: begin
                if (!AlarmEnable || stp) begin
                    state_n     = DONE;
                    remaining_n = '0;
                end else if (snz && (SnoozeCnt < SNOOZE_MAX)) begin
                    state_n      = SNOOZE;
                    snooze_cnt_n = SnoozeCnt + 2'd1;
                    remaining_n  = SNOOZE_LOAD;
                end else if (Remaining == '0) begin
                    state_n = DONE;
                end else begin
                    remaining_n = Remaining - 1'b1;
                    buzzer_n    = ~Buzzer;
                end
            end

            SNOOZE: begin
                if (!AlarmEnable || stp) begin
                    state_n     = DONE;
                    remaining_n = '0;
                end else if (Remaining == '0) begin
                    state_n     = RING;
                    remaining_n = RING_LOAD;
                    buzzer_n    = 1'b1;
                end else begin
                    remaining_n = Remaining - 1'b1;
                end
            end

            DONE: begin
                remaining_n = '0;
                if (!Alarm) begin
                    state_n      = IDLE;
                    snooze_cnt_n = 2'd0;
                end
            end

            default: begin
                state_n      = IDLE;
                remaining_n  = '0;
                snooze_cnt_n = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with RING_SECS=5, SNOOZE_SECS=3, MAX_SNOOZE=2.
module tb_alarm_snooze_ctrl;

    localparam int TIMER_W = 10;

    logic               Clock_1Sec = 1'b0;
    logic               Reset;
    logic               Alarm;
    logic               AlarmEnable;
    logic               SnoozeBtn;
    logic               StopBtn;
    logic               Buzzer;
    logic               Ringing;
    logic               Snoozing;
    logic [1:0]         SnoozeCnt;
    logic [TIMER_W-1:0] Remaining;

    int checks = 0;
    int errors = 0;

    alarm_snooze_ctrl #(
        .RING_SECS   (5),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2),
        .TIMER_W     (TIMER_W)
    ) dut (
        .Clock_1Sec  (Clock_1Sec),
        .Reset       (Reset),
        .Alarm       (Alarm),
        .AlarmEnable (AlarmEnable),
        .SnoozeBtn   (SnoozeBtn),
        .StopBtn     (StopBtn),
        .Buzzer      (Buzzer),
        .Ringing     (Ringing),
        .Snoozing    (Snoozing),
        .SnoozeCnt   (SnoozeCnt),
        .Remaining   (Remaining)
    );

    always #5 Clock_1Sec = ~Clock_1Sec;

    // Inputs change and outputs are sampled on the falling edge, half a period away from the active edge.
    task automatic step();
        @(negedge Clock_1Sec);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic buz, input logic rng, input logic snzg,
                             input logic [1:0] cnt, input logic [TIMER_W-1:0] rem);
        check({tag, ".Buzzer"},    32'(Buzzer),    32'(buz));
        check({tag, ".Ringing"},   32'(Ringing),   32'(rng));
        check({tag, ".Snoozing"},  32'(Snoozing),  32'(snzg));
        check({tag, ".SnoozeCnt"}, 32'(SnoozeCnt), 32'(cnt));
        check({tag, ".Remaining"}, 32'(Remaining), 32'(rem));
    endtask

    initial begin
        Reset = 1'b1; Alarm = 1'b0; AlarmEnable = 1'b1; SnoozeBtn = 1'b0; StopBtn = 1'b0;
        step(); step();
        check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        Reset = 1'b0;
        step();
        check_all("idle", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);

        // 1. undisturbed ring episode then auto-off
        Alarm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("ring1_%0d", i), ((i % 2) == 0), 1'b1, 1'b0, 2'd0, 10'(4 - i));
        end
        step();
        check_all("autooff", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        step();
        check("done_hold.Ringing", 32'(Ringing), 32'd0);
        Alarm = 1'b0;
        step();

        // 2. snooze in second ring cycle
        Alarm = 1'b1;
        step();
        check_all("ring2_c1", 1'b1, 1'b1, 1'b0, 2'd0, 10'd4);
        step();
        check_all("ring2_c2", 1'b0, 1'b1, 1'b0, 2'd0, 10'd3);
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        check_all("snz1_0", 1'b0, 1'b0, 1'b1, 2'd1, 10'd2);
        step();
        check_all("snz1_1", 1'b0, 1'b0, 1'b1, 2'd1, 10'd1);
        step();
        check_all("snz1_2", 1'b0, 1'b0, 1'b1, 2'd1, 10'd0);
        step();
        check_all("rering1", 1'b1, 1'b1, 1'b0, 2'd1, 10'd4);

        // 3. second snooze, then third press ignored and ring auto-offs
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        check_all("snz2_0", 1'b0, 1'b0, 1'b1, 2'd2, 10'd2);
        step(); step(); step();
        check_all("rering2", 1'b1, 1'b1, 1'b0, 2'd2, 10'd4);
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        check_all("snz3_ignored", 1'b0, 1'b1, 1'b0, 2'd2, 10'd3);
        step(); step(); step();
        check_all("ring3_last", 1'b1, 1'b1, 1'b0, 2'd2, 10'd0);
        step();
        check_all("autooff3", 1'b0, 1'b0, 1'b0, 2'd2, 10'd0);
        Alarm = 1'b0;
        step();
        check("cnt_cleared", 32'(SnoozeCnt), 32'd0);

        // 4. stop and snooze together: stop wins
        Alarm = 1'b1;
        step();
        SnoozeBtn = 1'b1; StopBtn = 1'b1;
        step();
        check_all("stop_snz", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        SnoozeBtn = 1'b0; StopBtn = 1'b0; Alarm = 1'b0;
        step();
        // held snooze counts once
        Alarm = 1'b1;
        step();
        SnoozeBtn = 1'b1;
        step();
        check_all("held_snz", 1'b0, 1'b0, 1'b1, 2'd1, 10'd2);
        step(); step(); step();
        check_all("held_rering", 1'b1, 1'b1, 1'b0, 2'd1, 10'd4);
        SnoozeBtn = 1'b0; StopBtn = 1'b1;
        step();
        check_all("stop_ring", 1'b0, 1'b0, 1'b0, 2'd1, 10'd0);
        StopBtn = 1'b0; Alarm = 1'b0;
        step();

        // 5. enable dropped during snooze; disabled alarm does not ring
        Alarm = 1'b1;
        step();
        SnoozeBtn = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        check("en_snz.Snoozing", 32'(Snoozing), 32'd1);
        AlarmEnable = 1'b0;
        step();
        check_all("en_drop", 1'b0, 1'b0, 1'b0, 2'd1, 10'd0);
        Alarm = 1'b0;
        step();
        Alarm = 1'b1;
        step(); step();
        check_all("disabled", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        AlarmEnable = 1'b1;
        step();
        check("en_late.Ringing", 32'(Ringing), 32'd0);
        Alarm = 1'b0;
        step();

        // 6. reset mid-ring with Alarm held high
        Alarm = 1'b1;
        step(); step();
        check_all("pre_reset", 1'b0, 1'b1, 1'b0, 2'd0, 10'd3);
        Reset = 1'b1;
        step();
        check_all("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        Reset = 1'b0;
        step(); step();
        check("no_rering.Ringing", 32'(Ringing), 32'd0);
        Alarm = 1'b0;
        step();
        Alarm = 1'b1;
        step();
        check_all("rering_after", 1'b1, 1'b1, 1'b0, 2'd0, 10'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
